// File: rtl/mpu_bus_sync.sv
// MPU strobe synchroniser and single-transaction request/acknowledge bridge onto the core bus.
// Each qualified MPU access yields exactly one bus_req, terminated by bus_ack or a timeout.
module mpu_bus_sync #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  _mpu_rd,
   input  logic                  _mpu_wr,
   input  logic                  _mpu_en,
   input  logic [1:0]            _mpu_be,
   input  logic [ADDR_WIDTH-1:0] mpu_addr_in,
   input  logic [DATA_WIDTH-1:0] mpu_data_in,
   output logic [DATA_WIDTH-1:0] mpu_data_out,
   output logic                  bus_req,
   output logic                  bus_wr,
   output logic [1:0]            bus_be,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_ack,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   output logic                  timeout_err
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] rd_sync;
   logic [SYNC_STAGES-1:0] wr_sync;
   logic [SYNC_STAGES-1:0] en_sync;
   logic                   rd_s;
   logic                   wr_s;
   logic                   en_s;
   logic                   start;
   logic                   busy;

   // NOTE: synchroniser flops reset to the inactive (high) strobe level, so leaving reset with a strobe held low is seen as a fresh assertion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_sync <= '1;
         wr_sync <= '1;
         en_sync <= '1;
      end else begin
         rd_sync <= {rd_sync[SYNC_STAGES-2:0], _mpu_rd};
         wr_sync <= {wr_sync[SYNC_STAGES-2:0], _mpu_wr};
         en_sync <= {en_sync[SYNC_STAGES-2:0], _mpu_en};
      end
   end

   assign rd_s  = ~rd_sync[SYNC_STAGES-1];
   assign wr_s  = ~wr_sync[SYNC_STAGES-1];
   assign en_s  = ~en_sync[SYNC_STAGES-1];
   assign start = en_s & (rd_s ^ wr_s);
   assign busy  = en_s & (rd_s | wr_s);

   // Address, data and byte enables are only sampled once the synced strobe qualifies, by which time they are stable.
   // NOTE: all state below uses non-blocking assignments so every flop sees the pre-edge values of the others.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         bus_req      <= 1'b0;
         bus_wr       <= 1'b0;
         bus_be       <= 2'b00;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         mpu_data_out <= '0;
         timeout_err  <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= REQ;
                  bus_req   <= 1'b1;
                  bus_wr    <= wr_s;
                  bus_be    <= ~_mpu_be;
                  bus_addr  <= mpu_addr_in;
                  bus_wdata <= mpu_data_in;
                  cnt       <= '0;
               end
            end
            REQ: begin
               // An ack arriving on the final allowed cycle takes priority over the timeout.
               if (bus_ack) begin
                  state   <= HOLD;
                  bus_req <= 1'b0;
                  if (!bus_wr) mpu_data_out <= bus_rdata;
               end else if (cnt == LAST_CNT) begin
                  state       <= HOLD;
                  bus_req     <= 1'b0;
                  timeout_err <= 1'b1;
                  if (!bus_wr) mpu_data_out <= '1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (!busy) state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mpu_bus_sync.sv
// Self-checking bench for mpu_bus_sync: directed scenarios plus randomized accesses,
// with a queue-based scoreboard checked by an independent bus monitor.
module tb_mpu_bus_sync;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int SS = 2;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          _mpu_rd = 1'b1;
   logic          _mpu_wr = 1'b1;
   logic          _mpu_en = 1'b1;
   logic [1:0]    _mpu_be = 2'b11;
   logic [AW-1:0] mpu_addr_in = '0;
   logic [DW-1:0] mpu_data_in = '0;
   logic [DW-1:0] mpu_data_out;
   logic          bus_req;
   logic          bus_wr;
   logic [1:0]    bus_be;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic          bus_ack = 1'b0;
   logic [DW-1:0] bus_rdata = '0;
   logic          timeout_err;

   mpu_bus_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), ._mpu_rd(_mpu_rd), ._mpu_wr(_mpu_wr), ._mpu_en(_mpu_en),
      ._mpu_be(_mpu_be), .mpu_addr_in(mpu_addr_in), .mpu_data_in(mpu_data_in),
      .mpu_data_out(mpu_data_out), .bus_req(bus_req), .bus_wr(bus_wr), .bus_be(bus_be),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic [1:0]    be;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            len;
      logic          tmo;
      logic [DW-1:0] dout;
   } exp_t;

   exp_t          exp_q[$];
   int            errors = 0;
   int            checks = 0;
   int            rise_cnt = 0;
   int            ack_delay = 1000;
   logic [DW-1:0] rdata_cfg = '0;
   logic [DW-1:0] last_rd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Bus responder: acks after ack_delay cycles of bus_req, otherwise drives junk read data.
   initial begin
      int  cyc;
      bit  acked;
      cyc = 0;
      acked = 1'b0;
      forever begin
         @(negedge clk);
         bus_ack   = 1'b0;
         bus_rdata = DW'($urandom);
         if (bus_req && !reset) begin
            if (!acked && cyc == ack_delay) begin
               bus_ack   = 1'b1;
               bus_rdata = rdata_cfg;
               acked     = 1'b1;
            end
            cyc++;
         end else begin
            cyc   = 0;
            acked = 1'b0;
         end
      end
   end

   // Monitor: pops one expectation per bus_req rise, checks completion on the fall.
   initial begin
      bit   prev;
      bit   in_flight;
      bit   fall;
      int   len;
      exp_t cur;
      prev = 1'b0;
      in_flight = 1'b0;
      len = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev = 1'b0;
            in_flight = 1'b0;
         end else begin
            fall = prev && !bus_req;
            if (bus_req && !prev) begin
               rise_cnt++;
               len = 1;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  in_flight = 1'b0;
                  $display("FAIL unexpected_req: got req addr 0x%0h expected none at %0t", bus_addr, $time);
               end else begin
                  cur = exp_q.pop_front();
                  in_flight = 1'b1;
                  check("bus_wr", bus_wr, cur.wr);
                  check("bus_be", bus_be, cur.be);
                  check("bus_addr", bus_addr, cur.addr);
                  if (cur.wr) check("bus_wdata", bus_wdata, cur.wdata);
               end
            end else if (bus_req) begin
               len++;
            end else if (fall && in_flight) begin
               check("req_len", len, cur.len);
               check("timeout_err", timeout_err, cur.tmo);
               check("mpu_data_out", mpu_data_out, cur.dout);
               in_flight = 1'b0;
            end
            if (!fall && timeout_err) begin
               checks++;
               errors++;
               $display("FAIL spurious_timeout: got 1 expected 0 at %0t", $time);
            end
            prev = bus_req;
         end
      end
   end

   task automatic release_strobes();
      _mpu_rd = 1'b1;
      _mpu_wr = 1'b1;
      _mpu_en = 1'b1;
   endtask

   task automatic wait_rise(output int lat);
      lat = 0;
      while (!bus_req && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!bus_req) begin
         errors++;
         checks++;
         $display("FAIL req_never_rose: got 0 expected 1 at %0t", $time);
      end
   endtask

   task automatic wait_fall();
      int n;
      n = 0;
      while (bus_req && n < TO + 10) begin
         @(negedge clk);
         n++;
      end
      if (bus_req) begin
         errors++;
         checks++;
         $display("FAIL req_never_fell: got 1 expected 0 at %0t", $time);
      end
   endtask

   function automatic exp_t make_exp(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                     input logic [1:0] be_n, input int delay, input logic [DW-1:0] rdata);
      exp_t e;
      e.wr    = wr;
      e.be    = ~be_n;
      e.addr  = addr;
      e.wdata = data;
      e.tmo   = (delay >= TO);
      e.len   = e.tmo ? TO : delay + 1;
      e.dout  = wr ? last_rd : (e.tmo ? {DW{1'b1}} : rdata);
      return e;
   endfunction

   task automatic mpu_access(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [1:0] be_n, input int delay, input logic [DW-1:0] rdata,
                             input int hold, input bit early);
      exp_t e;
      int   lat;
      e = make_exp(wr, addr, data, be_n, delay, rdata);
      last_rd = e.dout;
      exp_q.push_back(e);
      ack_delay = delay;
      rdata_cfg = rdata;
      @(negedge clk);
      mpu_addr_in = addr;
      mpu_data_in = data;
      _mpu_be     = be_n;
      _mpu_en     = 1'b0;
      if (wr) _mpu_wr = 1'b0;
      else    _mpu_rd = 1'b0;
      wait_rise(lat);
      check("req_latency", lat, SS + 1);
      if (early) release_strobes();
      wait_fall();
      repeat (hold) @(negedge clk);
      release_strobes();
      repeat (SS + 1) @(negedge clk);
      check("held_data_out", mpu_data_out, last_rd);
      check("held_bus_addr", bus_addr, addr);
   endtask

   initial begin
      int   base;
      int   lat;
      exp_t e;

      repeat (3) @(negedge clk);
      check("rst_req", bus_req, 1'b0);
      check("rst_outputs", {bus_wr, bus_be, bus_addr, bus_wdata, mpu_data_out, timeout_err}, '0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_req", bus_req, 1'b0);

      // Write with byte enables, acked two cycles after request.
      mpu_access(1'b1, 16'h0123, 16'hBEEF, 2'b10, 2, 16'h0000, 0, 1'b0);
      // Read, then a write that must leave the read data untouched.
      mpu_access(1'b0, 16'h0040, 16'h1111, 2'b00, 0, 16'h5A5A, 1, 1'b0);
      mpu_access(1'b1, 16'h0041, 16'h2222, 2'b01, 1, 16'h9999, 0, 1'b0);
      // Timeout, then ack on the very last allowed cycle.
      mpu_access(1'b0, 16'h0080, 16'h0000, 2'b00, TO, 16'h7777, 0, 1'b0);
      mpu_access(1'b0, 16'h0081, 16'h0000, 2'b00, TO - 1, 16'h1234, 0, 1'b0);
      // Long strobe gives one request; back-to-back strobes give two.
      mpu_access(1'b0, 16'h0100, 16'h0000, 2'b00, 0, 16'hA5A5, 40, 1'b0);
      mpu_access(1'b0, 16'h0101, 16'h0000, 2'b00, 0, 16'h0F0F, 0, 1'b0);
      mpu_access(1'b1, 16'h0102, 16'h3C3C, 2'b00, 0, 16'h0000, 0, 1'b0);
      // Strobe released while the request is still pending.
      mpu_access(1'b1, 16'h0200, 16'hCAFE, 2'b00, 6, 16'h0000, 0, 1'b1);

      // Illegal combinations issue nothing.
      base = rise_cnt;
      @(negedge clk);
      _mpu_en = 1'b0;
      _mpu_rd = 1'b0;
      _mpu_wr = 1'b0;
      repeat (10) @(negedge clk);
      release_strobes();
      repeat (SS + 2) @(negedge clk);
      check("no_req_rd_wr", rise_cnt, base);
      _mpu_rd = 1'b0;
      repeat (10) @(negedge clk);
      release_strobes();
      repeat (SS + 2) @(negedge clk);
      check("no_req_en_high", rise_cnt, base);

      // Reset in the middle of a pending request.
      e = make_exp(1'b0, 16'h0777, 16'h0000, 2'b00, 1000, 16'h0000);
      exp_q.push_back(e);
      ack_delay = 1000;
      @(negedge clk);
      mpu_addr_in = 16'h0777;
      _mpu_be = 2'b00;
      _mpu_en = 1'b0;
      _mpu_rd = 1'b0;
      wait_rise(lat);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_rst_req", bus_req, 1'b0);
      check("async_rst_outputs", {bus_wr, bus_be, bus_addr, bus_wdata, mpu_data_out, timeout_err}, '0);
      last_rd = '0;
      e = make_exp(1'b0, 16'h0777, 16'h0000, 2'b00, 2, 16'hC3C3);
      last_rd = e.dout;
      exp_q.push_back(e);
      ack_delay = 2;
      rdata_cfg = 16'hC3C3;
      repeat (2) @(negedge clk);
      check("rst_queue_pending", exp_q.size(), 1);
      reset = 1'b0;
      wait_rise(lat);
      check("resync_latency", lat, SS + 1);
      wait_fall();
      release_strobes();
      repeat (SS + 1) @(negedge clk);
      check("resync_data_out", mpu_data_out, 16'hC3C3);

      // Randomized accesses against the reference model.
      for (int i = 0; i < 30; i++) begin
         mpu_access(1'($urandom), AW'($urandom), DW'($urandom), 2'($urandom),
                    int'($urandom_range(0, TO + 2)), DW'($urandom),
                    int'($urandom_range(0, 4)), ($urandom_range(0, 4) == 0));
      end

      repeat (5) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
